// File: rtl/mux8_2x1_arbiter_pkg.sv
// Shared encodings for the two-source byte-stream arbiter: FSM states and source IDs.
package mux8_2x1_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_A = 2'd1,
    ST_GNT_B = 2'd2
  } arb_state_e;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  // Round-robin hand-off: the pointer moves to whichever source did not just finish.
  function automatic logic other_src(input logic src);
    return ~src;
  endfunction

endpackage

// File: rtl/bit8_2to1mux.sv
// 8-bit 2:1 mux cell: sel = 0 passes in1, sel = 1 passes in2.
module bit8_2to1mux (
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic       sel,
  output logic [7:0] out
);

  assign out = sel ? in2 : in1;

endmodule

// File: rtl/mux8_arb_fsm.sv
// Packet-lock arbitration FSM: state, round-robin pointer, mux select and ready generation.
// MUX8_ARB_FIXED_PRIO_EN selects fixed A-first priority instead of round-robin.
module mux8_arb_fsm
  import mux8_2x1_arbiter_pkg::*;
#(
  parameter logic PTR_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_valid,
  input  logic       a_last,
  input  logic       b_valid,
  input  logic       b_last,
  input  logic       can_load,
  output arb_state_e state,
  output logic       sel,
  output logic       a_ready,
  output logic       b_ready
);

  arb_state_e state_r;
  logic       ptr_r;
  logic       a_acc_s;
  logic       b_acc_s;
  arb_state_e both_pick_s;

  // Grant decode: only the locked source may see ready, and only when the output stage can load.
  always_comb begin
    a_ready = (state_r == ST_GNT_A) & can_load;
    b_ready = (state_r == ST_GNT_B) & can_load;
    sel     = (state_r == ST_GNT_B);
    a_acc_s = a_valid & a_ready;
    b_acc_s = b_valid & b_ready;
`ifdef MUX8_ARB_FIXED_PRIO_EN
    both_pick_s = ST_GNT_A;
`else
    if (ptr_r == SRC_A) begin
      both_pick_s = ST_GNT_A;
    end else begin
      both_pick_s = ST_GNT_B;
    end
`endif
  end

  assign state = state_r;

  // Arbitration state and pointer; a grant is held until the locked source's last beat is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      ptr_r   <= PTR_INIT;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (a_valid && b_valid) begin
            state_r <= both_pick_s;
          end else if (a_valid) begin
            state_r <= ST_GNT_A;
          end else if (b_valid) begin
            state_r <= ST_GNT_B;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_GNT_A: begin
          if (a_acc_s && a_last) begin
            state_r <= ST_IDLE;
`ifdef MUX8_ARB_FIXED_PRIO_EN
            ptr_r   <= PTR_INIT;
`else
            ptr_r   <= other_src(SRC_A);
`endif
          end
        end
        ST_GNT_B: begin
          if (b_acc_s && b_last) begin
            state_r <= ST_IDLE;
`ifdef MUX8_ARB_FIXED_PRIO_EN
            ptr_r   <= PTR_INIT;
`else
            ptr_r   <= other_src(SRC_B);
`endif
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/mux8_2x1_arbiter.sv
// Packet-level arbiter merging two 8-bit valid/ready streams into one registered output stage.
// Optional macro MUX8_ARB_FIXED_PRIO_EN: fixed A-first priority instead of round-robin.
module mux8_2x1_arbiter
  import mux8_2x1_arbiter_pkg::*;
#(
  parameter int   DW       = 8,
  parameter logic PTR_INIT = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  input  logic [DW-1:0] a_data,
  input  logic          a_last,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [DW-1:0] b_data,
  input  logic          b_last,
  output logic          b_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          out_src,
  input  logic          out_ready,
  output logic          busy
);

  arb_state_e    state_s;
  logic          sel_s;
  logic          can_load_s;
  logic          beat_acc_s;
  logic          beat_last_s;
  logic [DW-1:0] mux_data_s;

  mux8_arb_fsm #(
    .PTR_INIT (PTR_INIT)
  ) u_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_valid  (a_valid),
    .a_last   (a_last),
    .b_valid  (b_valid),
    .b_last   (b_last),
    .can_load (can_load_s),
    .state    (state_s),
    .sel      (sel_s),
    .a_ready  (a_ready),
    .b_ready  (b_ready)
  );

  bit8_2to1mux u_mux (
    .in1 (a_data),
    .in2 (b_data),
    .sel (sel_s),
    .out (mux_data_s)
  );

  // Accept/load qualification for the single-entry output stage.
  always_comb begin
    can_load_s  = ~out_valid | out_ready;
    beat_acc_s  = (a_valid & a_ready) | (b_valid & b_ready);
    beat_last_s = sel_s ? b_last : a_last;
    busy        = (state_s != ST_IDLE) | out_valid;
  end

  // Output register: loads on an accepted beat, otherwise drains when the consumer takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= {DW{1'b0}};
      out_last  <= 1'b0;
      out_src   <= SRC_A;
    end else if (beat_acc_s) begin
      out_valid <= 1'b1;
      out_data  <= mux_data_s;
      out_last  <= beat_last_s;
      out_src   <= sel_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux8_2x1_arbiter.sv
// Self-checking bench: per-cycle vector table plus a beat scoreboard for order/loss/duplication.
module tb_mux8_2x1_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, a_last, a_ready;
  logic [7:0] a_data;
  logic       b_valid, b_last, b_ready;
  logic [7:0] b_data;
  logic       out_valid, out_last, out_src, out_ready, busy;
  logic [7:0] out_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux8_2x1_arbiter #(.DW(8), .PTR_INIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_src(out_src),
    .out_ready(out_ready), .busy(busy)
  );

  typedef struct packed {
    logic       rst;
    logic       av; logic [7:0] ad; logic al;
    logic       bv; logic [7:0] bd; logic bl;
    logic       ordy;
    logic       ear; logic ebr; logic eov; logic [7:0] eod; logic eol; logic eos; logic ebusy;
  } vec_t;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       s;
  } beat_t;

  vec_t  tbl [0:35];
  beat_t sb_q [$];

  function automatic vec_t mk(input logic r, input logic av, input logic [7:0] ad, input logic al,
                              input logic bv, input logic [7:0] bd, input logic bl, input logic ordy,
                              input logic ear, input logic ebr, input logic eov, input logic [7:0] eod,
                              input logic eol, input logic eos, input logic ebusy);
    vec_t v;
    v = '{r, av, ad, al, bv, bd, bl, ordy, ear, ebr, eov, eod, eol, eos, ebusy};
    return v;
  endfunction

  task automatic push(input logic [7:0] d, input logic l, input logic s);
    beat_t b;
    b = '{d, l, s};
    sb_q.push_back(b);
  endtask

  // Drive one cycle of stimulus after the edge, check outputs and scoreboard at the falling edge.
  task automatic apply(input vec_t v, input string tag, input int idx);
    logic [13:0] act, exp;
    beat_t       e;
    @(posedge clk); #1;
    rst_n = v.rst; a_valid = v.av; a_data = v.ad; a_last = v.al;
    b_valid = v.bv; b_data = v.bd; b_last = v.bl; out_ready = v.ordy;
    @(negedge clk);
    act = {a_ready, b_ready, out_valid, out_data, out_last, out_src, busy};
    exp = {v.ear, v.ebr, v.eov, v.eod, v.eol, v.eos, v.ebusy};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got ar=%b br=%b ov=%b od=%h ol=%b os=%b busy=%b expected ar=%b br=%b ov=%b od=%h ol=%b os=%b busy=%b",
               tag, idx, a_ready, b_ready, out_valid, out_data, out_last, out_src, busy,
               v.ear, v.ebr, v.eov, v.eod, v.eol, v.eos, v.ebusy);
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_extra %s[%0d] got beat %h/%b/%b expected none", tag, idx, out_data, out_last, out_src);
      end else begin
        e = sb_q.pop_front();
        if ({out_data, out_last, out_src} !== {e.d, e.l, e.s}) begin
          failures++;
          $display("FAIL sb_beat %s[%0d] got %h/%b/%b expected %h/%b/%b",
                   tag, idx, out_data, out_last, out_src, e.d, e.l, e.s);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; a_valid = 1'b1; a_data = 8'h11; a_last = 1'b0;
    b_valid = 1'b0; b_data = 8'h00; b_last = 1'b0; out_ready = 1'b1;

    // reset release, single source, contention, backpressure, stalled lock, single-beat packet
    tbl[0]  = mk(1'b1, 1'b1,8'h11,1'b0, 1'b0,8'h00,1'b0, 1'b1, 1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0);
    tbl[1]  = mk(1'b1, 1'b1,8'h11,1'b0, 1'b0,8'h00,1'b0, 1'b1, 1'b1,1'b0,1'b0,8'h00,1'b0,1'b0,1'b1);
    tbl[2]  = mk(1'b1, 1'b1,8'h22,1'b0, 1'b0,8'h00,1'b0, 1'b1, 1'b1,1'b0,1'b1,8'h11,1'b0,1'b0,1'b1);
    tbl[3]  = mk(1'b1, 1'b1,8'h33,1'b1, 1'b0,8'h00,1'b0, 1'b1, 1'b1,1'b0,1'b1,8'h22,1'b0,1'b0,1'b1);
    tbl[4]  = mk(1'b1, 1'b0,8'h00,1'b0, 1'b0,8'h00,1'b0, 1'b1, 1'b0,1'b0,1'b1,8'h33,1'b1,1'b0,1'b1);
    tbl[5]  = mk(1'b1, 1'b0,8'h00,1'b0, 1'b0,8'h00,1'b0, 1'b1, 1'b0,1'b0,1'b0,8'h33,1'b1,1'b0,1'b0);
    tbl[6]  = mk(1'b1, 1'b1,8'hA0,1'b0, 1'b1,8'hB0,1'b0, 1'b1, 1'b0,1'b0,1'b0,8'h33,1'b1,1'b0,1'b0);
    tbl[7]  = mk(1'b1, 1'b1,8'hA0,1'b0, 1'b1,8'hB0,1'b0, 1'b1, 1'b0,1'b1,1'b0,8'h33,1'b1,1'b0,1'b1);
    tbl[8]  = mk(1'b1, 1'b1,8'hA0,1'b0, 1'b1,8'hB1,1'b1, 1'b1, 1'b0,1'b1,1'b1,8'hB0,1'b0,1'b1,1'b1);
    tbl[9]  = mk(1'b1, 1'b1,8'hA0,1'b0, 1'b1,8'hB0,1'b0, 1'b1, 1'b0,1'b0,1'b1,8'hB1,1'b1,1'b1,1'b1);
    tbl[10] = mk(1'b1, 1'b1,8'hA0,1'b0, 1'b1,8'hB0,1'b0, 1'b1, 1'b1,1'b0,1'b0,8'hB1,1'b1,1'b1,1'b1);
    tbl[11] = mk(1'b1, 1'b1,8'hA1,1'b1, 1'b1,8'hB0,1'b0, 1'b1, 1'b1,1'b0,1'b1,8'hA0,1'b0,1'b0,1'b1);
    tbl[12] = mk(1'b1, 1'b1,8'hA0,1'b0, 1'b1,8'hB0,1'b0, 1'b1, 1'b0,1'b0,1'b1,8'hA1,1'b1,1'b0,1'b1);
    tbl[13] = mk(1'b1, 1'b1,8'hA0,1'b0, 1'b1,8'hB0,1'b0, 1'b1, 1'b0,1'b1,1'b0,8'hA1,1'b1,1'b0,1'b1);
    tbl[14] = mk(1'b1, 1'b1,8'hA0,1'b0, 1'b1,8'hB1,1'b1, 1'b1, 1'b0,1'b1,1'b1,8'hB0,1'b0,1'b1,1'b1);
    tbl[15] = mk(1'b1, 1'b0,8'h00,1'b0, 1'b0,8'h00,1'b0, 1'b1, 1'b0,1'b0,1'b1,8'hB1,1'b1,1'b1,1'b1);
    tbl[16] = mk(1'b1, 1'b0,8'h00,1'b0, 1'b0,8'h00,1'b0, 1'b1, 1'b0,1'b0,1'b0,8'hB1,1'b1,1'b1,1'b0);
    tbl[17] = mk(1'b1, 1'b1,8'hC0,1'b0, 1'b0,8'h00,1'b0, 1'b1, 1'b0,1'b0,1'b0,8'hB1,1'b1,1'b1,1'b0);
    tbl[18] = mk(1'b1, 1'b1,8'hC0,1'b0, 1'b0,8'h00,1'b0, 1'b1, 1'b1,1'b0,1'b0,8'hB1,1'b1,1'b1,1'b1);
    tbl[19] = mk(1'b1, 1'b1,8'hC1,1'b0, 1'b0,8'h00,1'b0, 1'b1, 1'b1,1'b0,1'b1,8'hC0,1'b0,1'b0,1'b1);
    tbl[20] = mk(1'b1, 1'b1,8'hC2,1'b0, 1'b0,8'h00,1'b0, 1'b0, 1'b0,1'b0,1'b1,8'hC1,1'b0,1'b0,1'b1);
    tbl[21] = mk(1'b1, 1'b1,8'hC2,1'b0, 1'b0,8'h00,1'b0, 1'b0, 1'b0,1'b0,1'b1,8'hC1,1'b0,1'b0,1'b1);
    tbl[22] = mk(1'b1, 1'b1,8'hC2,1'b0, 1'b0,8'h00,1'b0, 1'b0, 1'b0,1'b0,1'b1,8'hC1,1'b0,1'b0,1'b1);
    tbl[23] = mk(1'b1, 1'b1,8'hC2,1'b0, 1'b0,8'h00,1'b0, 1'b1, 1'b1,1'b0,1'b1,8'hC1,1'b0,1'b0,1'b1);
    tbl[24] = mk(1'b1, 1'b1,8'hC3,1'b1, 1'b0,8'h00,1'b0, 1'b1, 1'b1,1'b0,1'b1,8'hC2,1'b0,1'b0,1'b1);
    tbl[25] = mk(1'b1, 1'b0,8'h00,1'b0, 1'b0,8'h00,1'b0, 1'b1, 1'b0,1'b0,1'b1,8'hC3,1'b1,1'b0,1'b1);
    tbl[26] = mk(1'b1, 1'b0,8'h00,1'b0, 1'b0,8'h00,1'b0, 1'b1, 1'b0,1'b0,1'b0,8'hC3,1'b1,1'b0,1'b0);
    tbl[27] = mk(1'b1, 1'b1,8'hD0,1'b0, 1'b0,8'h00,1'b0, 1'b1, 1'b0,1'b0,1'b0,8'hC3,1'b1,1'b0,1'b0);
    tbl[28] = mk(1'b1, 1'b1,8'hD0,1'b0, 1'b0,8'h00,1'b0, 1'b1, 1'b1,1'b0,1'b0,8'hC3,1'b1,1'b0,1'b1);
    tbl[29] = mk(1'b1, 1'b0,8'h00,1'b0, 1'b0,8'h00,1'b0, 1'b1, 1'b1,1'b0,1'b1,8'hD0,1'b0,1'b0,1'b1);
    tbl[30] = mk(1'b1, 1'b0,8'h00,1'b0, 1'b1,8'hE0,1'b1, 1'b1, 1'b1,1'b0,1'b0,8'hD0,1'b0,1'b0,1'b1);
    tbl[31] = mk(1'b1, 1'b1,8'hD1,1'b1, 1'b1,8'hE0,1'b1, 1'b1, 1'b1,1'b0,1'b0,8'hD0,1'b0,1'b0,1'b1);
    tbl[32] = mk(1'b1, 1'b0,8'h00,1'b0, 1'b1,8'hE0,1'b1, 1'b1, 1'b0,1'b0,1'b1,8'hD1,1'b1,1'b0,1'b1);
    tbl[33] = mk(1'b1, 1'b0,8'h00,1'b0, 1'b1,8'hE0,1'b1, 1'b1, 1'b0,1'b1,1'b0,8'hD1,1'b1,1'b0,1'b1);
    tbl[34] = mk(1'b1, 1'b0,8'h00,1'b0, 1'b0,8'h00,1'b0, 1'b1, 1'b0,1'b0,1'b1,8'hE0,1'b1,1'b1,1'b1);
    tbl[35] = mk(1'b1, 1'b0,8'h00,1'b0, 1'b0,8'h00,1'b0, 1'b1, 1'b0,1'b0,1'b0,8'hE0,1'b1,1'b1,1'b0);

    // Reset held two cycles with A requesting: everything quiet.
    for (int i = 0; i < 2; i++) begin
      apply(mk(1'b0, 1'b1,8'h11,1'b0, 1'b0,8'h00,1'b0, 1'b1, 1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0), "rst", i);
    end

    push(8'h11,1'b0,1'b0); push(8'h22,1'b0,1'b0); push(8'h33,1'b1,1'b0);
    push(8'hB0,1'b0,1'b1); push(8'hB1,1'b1,1'b1); push(8'hA0,1'b0,1'b0); push(8'hA1,1'b1,1'b0);
    push(8'hB0,1'b0,1'b1); push(8'hB1,1'b1,1'b1);
    push(8'hC0,1'b0,1'b0); push(8'hC1,1'b0,1'b0); push(8'hC2,1'b0,1'b0); push(8'hC3,1'b1,1'b0);
    push(8'hD0,1'b0,1'b0); push(8'hD1,1'b1,1'b0); push(8'hE0,1'b1,1'b1);
    for (int i = 0; i < 36; i++) begin
      apply(tbl[i], "tbl", i);
    end

    // Reset mid-packet with pointer at B: held beat and lock dropped, pointer back to A.
    push(8'hF0,1'b1,1'b0); push(8'h60,1'b0,1'b0); push(8'h61,1'b0,1'b0);
    push(8'h5A,1'b1,1'b0); push(8'h48,1'b1,1'b1);
    apply(mk(1'b1, 1'b1,8'hF0,1'b1, 1'b0,8'h00,1'b0, 1'b1, 1'b0,1'b0,1'b0,8'hE0,1'b1,1'b1,1'b0), "mid", 0);
    apply(mk(1'b1, 1'b1,8'hF0,1'b1, 1'b0,8'h00,1'b0, 1'b1, 1'b1,1'b0,1'b0,8'hE0,1'b1,1'b1,1'b1), "mid", 1);
    apply(mk(1'b1, 1'b1,8'h60,1'b0, 1'b0,8'h00,1'b0, 1'b1, 1'b0,1'b0,1'b1,8'hF0,1'b1,1'b0,1'b1), "mid", 2);
    apply(mk(1'b1, 1'b1,8'h60,1'b0, 1'b0,8'h00,1'b0, 1'b1, 1'b1,1'b0,1'b0,8'hF0,1'b1,1'b0,1'b1), "mid", 3);
    apply(mk(1'b1, 1'b1,8'h61,1'b0, 1'b0,8'h00,1'b0, 1'b1, 1'b1,1'b0,1'b1,8'h60,1'b0,1'b0,1'b1), "mid", 4);
    apply(mk(1'b0, 1'b1,8'h62,1'b0, 1'b0,8'h00,1'b0, 1'b1, 1'b1,1'b0,1'b1,8'h61,1'b0,1'b0,1'b1), "mid", 5);
    apply(mk(1'b0, 1'b1,8'h62,1'b0, 1'b1,8'h48,1'b1, 1'b1, 1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0), "mid", 6);
    apply(mk(1'b1, 1'b1,8'h62,1'b0, 1'b1,8'h48,1'b1, 1'b1, 1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0), "mid", 7);
    apply(mk(1'b1, 1'b1,8'h5A,1'b1, 1'b1,8'h48,1'b1, 1'b1, 1'b1,1'b0,1'b0,8'h00,1'b0,1'b0,1'b1), "mid", 8);
    apply(mk(1'b1, 1'b0,8'h00,1'b0, 1'b1,8'h48,1'b1, 1'b1, 1'b0,1'b0,1'b1,8'h5A,1'b1,1'b0,1'b1), "mid", 9);
    apply(mk(1'b1, 1'b0,8'h00,1'b0, 1'b1,8'h48,1'b1, 1'b1, 1'b0,1'b1,1'b0,8'h5A,1'b1,1'b0,1'b1), "mid", 10);
    apply(mk(1'b1, 1'b0,8'h00,1'b0, 1'b0,8'h00,1'b0, 1'b1, 1'b0,1'b0,1'b1,8'h48,1'b1,1'b1,1'b1), "mid", 11);
    apply(mk(1'b1, 1'b0,8'h00,1'b0, 1'b0,8'h00,1'b0, 1'b1, 1'b0,1'b0,1'b0,8'h48,1'b1,1'b1,1'b0), "mid", 12);

    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got %0d beats outstanding expected 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
